// File: rtl/student_i2s_tx_pkg.sv
// Shared types for the I2S transmitter: FSM state encoding and frame-length helper.
package student_i2s_tx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } i2s_tx_state_e;

    localparam int SLOT_WIDTH_DEFAULT = 32;
    localparam int FRAME_BITS         = 2 * SLOT_WIDTH_DEFAULT;

    function automatic int frame_bits(input int slot_width);
        return 2 * slot_width;
    endfunction

endpackage

// File: rtl/student_sync_fifo.sv
// Pointer-based synchronous FIFO with registered occupancy; a pop frees room for a same-cycle push.
module student_sync_fifo #(
    parameter int DATA_WIDTH = 24,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          i_wr_en,
    input  logic [DATA_WIDTH-1:0]         i_wr_data,
    input  logic                          i_rd_en,
    output logic [DATA_WIDTH-1:0]         o_rd_data,
    output logic                          o_full,
    output logic                          o_empty,
    output logic [$clog2(FIFO_DEPTH):0]   o_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [LW-1:0]         r_level;
    logic                  w_push;
    logic                  w_pop;

    assign o_full    = (r_level == LW'(FIFO_DEPTH));
    assign o_empty   = (r_level == '0);
    assign w_pop     = i_rd_en && !o_empty;
    assign w_push    = i_wr_en && (!o_full || w_pop);
    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_level   = r_level;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
    end

endmodule

// File: rtl/student_i2s_tx.sv
// Philips I2S master playing a mono FIR sample stream on both slots, buffered by a small FIFO.
// Optional underrun counter port enabled by defining STUDENT_I2S_TX_UNDERRUN_CNT_EN.
module student_i2s_tx
    import student_i2s_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 24,
    parameter int SLOT_WIDTH = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int CLK_DIV    = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          sample_valid_i,
    input  logic [DATA_WIDTH-1:0]         sample_i,
    input  logic                          enable_i,
    output logic                          sck_o,
    output logic                          ws_o,
    output logic                          sd_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic                          overflow_o,
    output logic                          underrun_o
`ifdef STUDENT_I2S_TX_UNDERRUN_CNT_EN
    ,
    output logic [15:0]                   underrun_cnt_o
`endif
);

    localparam int LW    = $clog2(FIFO_DEPTH) + 1;
    localparam int FRAME = frame_bits(SLOT_WIDTH);
    localparam int BCW   = $clog2(FRAME);
    localparam int DIVW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    i2s_tx_state_e         r_state;
    i2s_tx_state_e         w_next_state;

    logic [DIVW-1:0]       r_div;
    logic                  r_sck;
    logic                  r_first;
    logic [BCW-1:0]        r_bitcnt;
    logic [DATA_WIDTH-1:0] r_shreg;
    logic                  r_ws;
    logic                  r_sd;
    logic                  r_overflow;
    logic                  r_underrun;

    logic                  w_full;
    logic                  w_empty;
    logic [LW-1:0]         w_level;
    logic [DATA_WIDTH-1:0] w_rd_data;

    logic                  w_div_wrap;
    logic                  w_sck_fall;
    logic [BCW-1:0]        w_bitcnt_next;
    logic                  w_frame_start;
    logic                  w_stop;
    logic                  w_pop;
    logic                  w_underrun_set;
    logic                  w_ws_next;
    logic [BCW-1:0]        w_k;
    logic                  w_sd_next;

    student_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .i_wr_en   (sample_valid_i),
        .i_wr_data (sample_i),
        .i_rd_en   (w_pop),
        .o_rd_data (w_rd_data),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_level   (w_level)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= IDLE;
        else         r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: if (enable_i) w_next_state = FILL;
            FILL: begin
                if (!enable_i)                              w_next_state = IDLE;
                else if (w_level >= LW'(FIFO_DEPTH / 2))    w_next_state = RUN;
            end
            RUN:  if (w_stop) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // The first falling edge of a run is itself a frame start, so bitcnt stays at 0 there.
    always_comb begin
        w_div_wrap     = (r_div == DIVW'(CLK_DIV - 1));
        w_sck_fall     = (r_state == RUN) && w_div_wrap && r_sck;
        if (r_first || (r_bitcnt == BCW'(FRAME - 1))) w_bitcnt_next = '0;
        else                                          w_bitcnt_next = r_bitcnt + BCW'(1);
        w_frame_start  = w_sck_fall && (w_bitcnt_next == '0);
        w_stop         = w_frame_start && !enable_i;
        w_pop          = w_frame_start && enable_i && !w_empty;
        w_underrun_set = w_frame_start && enable_i && w_empty;
        w_ws_next      = (w_bitcnt_next >= BCW'(SLOT_WIDTH));
        w_k            = w_ws_next ? (w_bitcnt_next - BCW'(SLOT_WIDTH)) : w_bitcnt_next;
        w_sd_next      = 1'b0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (w_k == BCW'(DATA_WIDTH - i)) w_sd_next = r_shreg[i];
        end
    end

    // Serializer: everything visible changes only on the clk edge where SCK falls.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_div      <= '0;
            r_sck      <= 1'b0;
            r_first    <= 1'b1;
            r_bitcnt   <= '0;
            r_shreg    <= '0;
            r_ws       <= 1'b0;
            r_sd       <= 1'b0;
            r_overflow <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_overflow <= sample_valid_i && w_full && !w_pop;
            r_underrun <= w_underrun_set;
            if ((r_state != RUN) || w_stop) begin
                r_div    <= '0;
                r_sck    <= 1'b0;
                r_first  <= 1'b1;
                r_bitcnt <= '0;
                r_ws     <= 1'b0;
                r_sd     <= 1'b0;
            end else begin
                r_div <= w_div_wrap ? '0 : r_div + DIVW'(1);
                if (w_div_wrap) r_sck <= !r_sck;
                if (w_sck_fall) begin
                    r_first  <= 1'b0;
                    r_bitcnt <= w_bitcnt_next;
                    r_ws     <= w_ws_next;
                    r_sd     <= w_sd_next;
                end
                if (w_frame_start) r_shreg <= w_empty ? '0 : w_rd_data;
            end
        end
    end

`ifdef STUDENT_I2S_TX_UNDERRUN_CNT_EN
    logic [15:0] r_underrun_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                                         r_underrun_cnt <= '0;
        else if (w_underrun_set && (r_underrun_cnt != 16'hFFFF)) r_underrun_cnt <= r_underrun_cnt + 16'd1;
    end

    assign underrun_cnt_o = r_underrun_cnt;
`endif

    assign sck_o        = r_sck;
    assign ws_o         = r_ws;
    assign sd_o         = r_sd;
    assign fifo_level_o = w_level;
    assign overflow_o   = r_overflow;
    assign underrun_o   = r_underrun;

endmodule

// File: tb/tb_student_i2s_tx.sv
// Scoreboard bench for student_i2s_tx: written samples are queued and compared against decoded I2S frames.
module tb_student_i2s_tx;

    localparam int DW      = 24;
    localparam int SW      = 32;
    localparam int DEPTH   = 8;
    localparam int CLK_DIV = 2;
    localparam int LW      = $clog2(DEPTH) + 1;
    localparam logic [63:0] EXP_WS = {32'hFFFF_FFFF, 32'h0000_0000};

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          sample_valid_i = 1'b0;
    logic [DW-1:0] sample_i = '0;
    logic          enable_i = 1'b0;
    logic          sck_o;
    logic          ws_o;
    logic          sd_o;
    logic [LW-1:0] fifo_level_o;
    logic          overflow_o;
    logic          underrun_o;
`ifdef STUDENT_I2S_TX_UNDERRUN_CNT_EN
    logic [15:0]   underrun_cnt_o;
`endif

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] exp_q[$];
    int            model_level = 0;

    logic [63:0]   cap_sd;
    logic [63:0]   cap_ws;
    int            cap_uf;

    student_i2s_tx #(
        .DATA_WIDTH (DW),
        .SLOT_WIDTH (SW),
        .FIFO_DEPTH (DEPTH),
        .CLK_DIV    (CLK_DIV)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .sample_valid_i (sample_valid_i),
        .sample_i       (sample_i),
        .enable_i       (enable_i),
        .sck_o          (sck_o),
        .ws_o           (ws_o),
        .sd_o           (sd_o),
        .fifo_level_o   (fifo_level_o),
        .overflow_o     (overflow_o),
        .underrun_o     (underrun_o)
`ifdef STUDENT_I2S_TX_UNDERRUN_CNT_EN
        ,
        .underrun_cnt_o (underrun_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    // Expected SD bit per falling edge: one-SCK delay, MSB first, same word in both slots.
    function automatic logic [63:0] model_sd(input logic [DW-1:0] s);
        logic [63:0] v;
        v = '0;
        for (int k = 1; k <= DW; k++) begin
            v[k]      = s[DW-k];
            v[SW + k] = s[DW-k];
        end
        return v;
    endfunction

    // Pops the scoreboard for the next frame; an empty queue means an underrun frame of zeros.
    task automatic next_expected(output logic [DW-1:0] s, output int uf);
        if (exp_q.size() > 0) begin
            s  = exp_q.pop_front();
            uf = 0;
            model_level--;
        end else begin
            s  = '0;
            uf = 1;
        end
    endtask

    task automatic write_sample(input logic [DW-1:0] d, output int ov);
        sample_i       = d;
        sample_valid_i = 1'b1;
        @(negedge clk_i);
        sample_valid_i = 1'b0;
        ov = int'(overflow_o);
        if (model_level < DEPTH) begin
            exp_q.push_back(d);
            model_level++;
        end
    endtask

    task automatic capture(input int start, input int n);
        int   got;
        int   budget;
        logic prev;
        got    = 0;
        budget = n * 4 * CLK_DIV + 20;
        prev   = sck_o;
        if (start == 0) begin
            cap_sd = '0;
            cap_ws = '0;
            cap_uf = 0;
        end
        while ((got < n) && (budget > 0)) begin
            @(negedge clk_i);
            budget--;
            if (underrun_o) cap_uf++;
            if (prev && !sck_o) begin
                cap_sd[start + got] = sd_o;
                cap_ws[start + got] = ws_o;
                got++;
            end
            prev = sck_o;
        end
        if (got < n) begin
            checks++;
            errors++;
            $display("[TB] FAIL capture_timeout: got %0d falling edges, required %0d", got, n);
        end
    endtask

    task automatic test_reset;
        rst_ni   = 1'b0;
        enable_i = 1'b0;
        repeat (2) @(negedge clk_i);
        checks++; if (sck_o !== 1'b0)        begin errors++; $display("[TB] FAIL reset_sck: got %b want 0", sck_o); end
        checks++; if (ws_o !== 1'b0)         begin errors++; $display("[TB] FAIL reset_ws: got %b want 0", ws_o); end
        checks++; if (sd_o !== 1'b0)         begin errors++; $display("[TB] FAIL reset_sd: got %b want 0", sd_o); end
        checks++; if (fifo_level_o !== '0)   begin errors++; $display("[TB] FAIL reset_level: got %0d want 0", fifo_level_o); end
        checks++; if (overflow_o !== 1'b0)   begin errors++; $display("[TB] FAIL reset_overflow: got %b want 0", overflow_o); end
        checks++; if (underrun_o !== 1'b0)   begin errors++; $display("[TB] FAIL reset_underrun: got %b want 0", underrun_o); end
        rst_ni = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_fill_and_frames;
        logic [DW-1:0] s;
        int            uf;
        int            ov;
        int            sck_seen;
        write_sample(24'h7FFFFF, ov);
        write_sample(24'h800001, ov);
        write_sample(24'h123456, ov);
        checks++; if (fifo_level_o !== LW'(3)) begin errors++; $display("[TB] FAIL fill_level3: got %0d want 3", fifo_level_o); end
        enable_i = 1'b1;
        sck_seen = 0;
        repeat (30) begin
            @(negedge clk_i);
            if (sck_o !== 1'b0) sck_seen++;
        end
        checks++; if (sck_seen != 0) begin errors++; $display("[TB] FAIL fill_hold: sck high on %0d cycles, want 0", sck_seen); end
        write_sample(24'hA5A5A5, ov);
        checks++; if (fifo_level_o !== LW'(4)) begin errors++; $display("[TB] FAIL fill_level4: got %0d want 4", fifo_level_o); end
        for (int f = 0; f < 4; f++) begin
            capture(0, 64);
            next_expected(s, uf);
            checks++; if (cap_sd !== model_sd(s)) begin errors++; $display("[TB] FAIL frame%0d_sd: got %h want %h", f, cap_sd, model_sd(s)); end
            checks++; if (cap_ws !== EXP_WS)      begin errors++; $display("[TB] FAIL frame%0d_ws: got %h want %h", f, cap_ws, EXP_WS); end
            checks++; if (cap_uf != uf)           begin errors++; $display("[TB] FAIL frame%0d_underrun: got %0d want %0d", f, cap_uf, uf); end
        end
    endtask

    task automatic test_underrun;
        logic [DW-1:0] s;
        int            uf;
`ifdef STUDENT_I2S_TX_UNDERRUN_CNT_EN
        logic [15:0]   cnt_before;
`endif
        for (int f = 0; f < 2; f++) begin
`ifdef STUDENT_I2S_TX_UNDERRUN_CNT_EN
            cnt_before = underrun_cnt_o;
`endif
            capture(0, 64);
            next_expected(s, uf);
            checks++; if (cap_sd !== model_sd(s)) begin errors++; $display("[TB] FAIL underrun%0d_sd: got %h want %h", f, cap_sd, model_sd(s)); end
            checks++; if (cap_ws !== EXP_WS)      begin errors++; $display("[TB] FAIL underrun%0d_ws: got %h want %h", f, cap_ws, EXP_WS); end
            checks++; if (cap_uf != uf)           begin errors++; $display("[TB] FAIL underrun%0d_pulses: got %0d want %0d", f, cap_uf, uf); end
`ifdef STUDENT_I2S_TX_UNDERRUN_CNT_EN
            checks++; if (underrun_cnt_o !== cnt_before + 16'd1) begin errors++; $display("[TB] FAIL underrun%0d_cnt: got %0d want %0d", f, underrun_cnt_o, cnt_before + 16'd1); end
`endif
        end
    endtask

    task automatic test_stop_midframe;
        logic [DW-1:0] s;
        int            uf;
        int            busy;
        int            uf_after;
        capture(0, 30);
        enable_i = 1'b0;
        capture(30, 34);
        next_expected(s, uf);
        checks++; if (cap_sd !== model_sd(s)) begin errors++; $display("[TB] FAIL stop_sd: got %h want %h", cap_sd, model_sd(s)); end
        checks++; if (cap_ws !== EXP_WS)      begin errors++; $display("[TB] FAIL stop_ws: got %h want %h", cap_ws, EXP_WS); end
        checks++; if (cap_uf != uf)           begin errors++; $display("[TB] FAIL stop_pulses: got %0d want %0d", cap_uf, uf); end
        busy     = 0;
        uf_after = 0;
        repeat (8) begin
            @(negedge clk_i);
            if (underrun_o) uf_after++;
        end
        repeat (40) begin
            @(negedge clk_i);
            if (underrun_o) uf_after++;
            if ((sck_o !== 1'b0) || (ws_o !== 1'b0) || (sd_o !== 1'b0)) busy++;
        end
        checks++; if (busy != 0)     begin errors++; $display("[TB] FAIL stop_idle: outputs active on %0d cycles, want 0", busy); end
        checks++; if (uf_after != 0) begin errors++; $display("[TB] FAIL stop_no_underrun: got %0d pulses want 0", uf_after); end
        checks++; if (fifo_level_o !== LW'(model_level)) begin errors++; $display("[TB] FAIL stop_level: got %0d want %0d", fifo_level_o, model_level); end
    endtask

    task automatic test_overflow;
        int ov;
        int ov_total;
        int ov_after;
        ov_total = 0;
        ov_after = 0;
        for (int i = 0; i < 9; i++) begin
            write_sample(DW'($urandom()) | 24'h400000, ov);
            ov_total += ov;
        end
        repeat (2) begin
            @(negedge clk_i);
            if (overflow_o) ov_after++;
        end
        checks++; if (ov_total != 1)                begin errors++; $display("[TB] FAIL overflow_pulses: got %0d want 1", ov_total); end
        checks++; if (ov_after != 0)                begin errors++; $display("[TB] FAIL overflow_width: got %0d extra cycles want 0", ov_after); end
        checks++; if (fifo_level_o !== LW'(DEPTH)) begin errors++; $display("[TB] FAIL overflow_level: got %0d want %0d", fifo_level_o, DEPTH); end
    endtask

    task automatic test_reset_midframe;
        logic [DW-1:0] s;
        int            uf;
        int            ov;
        int            wait_cnt;
        enable_i = 1'b1;
        capture(0, 64);
        next_expected(s, uf);
        checks++; if (cap_sd !== model_sd(s)) begin errors++; $display("[TB] FAIL retained_sd: got %h want %h", cap_sd, model_sd(s)); end
        checks++; if (cap_uf != uf)           begin errors++; $display("[TB] FAIL retained_pulses: got %0d want %0d", cap_uf, uf); end
        checks++; if (fifo_level_o !== LW'(model_level)) begin errors++; $display("[TB] FAIL retained_level: got %0d want %0d", fifo_level_o, model_level); end
        capture(0, 40);
        wait_cnt = 0;
        while ((sck_o !== 1'b1) && (wait_cnt < 10)) begin
            @(negedge clk_i);
            wait_cnt++;
        end
        #1 rst_ni = 1'b0;
        #1;
        checks++; if (sck_o !== 1'b0)      begin errors++; $display("[TB] FAIL midreset_sck: got %b want 0", sck_o); end
        checks++; if (ws_o !== 1'b0)       begin errors++; $display("[TB] FAIL midreset_ws: got %b want 0", ws_o); end
        checks++; if (sd_o !== 1'b0)       begin errors++; $display("[TB] FAIL midreset_sd: got %b want 0", sd_o); end
        checks++; if (fifo_level_o !== '0) begin errors++; $display("[TB] FAIL midreset_level: got %0d want 0", fifo_level_o); end
        exp_q.delete();
        model_level = 0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        write_sample(24'h0F0F0F, ov);
        write_sample(24'h3C3C3C, ov);
        write_sample(24'h555555, ov);
        write_sample(24'h00FF00, ov);
        capture(0, 64);
        next_expected(s, uf);
        checks++; if (cap_sd !== model_sd(s)) begin errors++; $display("[TB] FAIL rerun_sd: got %h want %h", cap_sd, model_sd(s)); end
        checks++; if (cap_ws !== EXP_WS)      begin errors++; $display("[TB] FAIL rerun_ws: got %h want %h", cap_ws, EXP_WS); end
        checks++; if (fifo_level_o !== LW'(model_level)) begin errors++; $display("[TB] FAIL rerun_level: got %0d want %0d", fifo_level_o, model_level); end
        enable_i = 1'b0;
        repeat (300) @(negedge clk_i);
    endtask

    initial begin
        test_reset();
        test_fill_and_frames();
        test_underrun();
        test_stop_midframe();
        test_overflow();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
